regfile_mp_clr: RTL and testbench

- Parametrised successor to the single-write, dual-read CPU register file.
- Two write ports with fixed priority, two read ports with same-cycle write-to-read bypass, and an optional hardwired-zero register 0.
- A sequential clear engine zeroes the whole array after reset or on request.
- Sits in the decode/writeback stage of the pipelined datapath; the second write port serves the load/multiply return path.

---
 rtl/regfile_mp_clr.sv | 109 ++++++++++
 tb/tb_regfile_mp_clr.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_clr.sv
// Register file with two prioritized write ports and two bypassing read ports.
// A sequential clear engine zeroes the whole array after reset or on clr_req.
//
//   state | meaning
//   CLEAR | zero mem[cnt] each cycle; reads return 0, writes and clr_req ignored
//   READY | array usable; writes land, reads bypass same-cycle writes
module regfile_mp_clr #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam bit ZERO_EN = (ZERO_REG != 0);

  state_t state, stateNext;
  logic [ADDR_W-1:0] cnt, cntNext;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wrOpen;
  logic keep0, keep1;

  assign ready  = (state == READY);
  assign wrOpen = ready && !clr_req;
  assign keep0  = we0 && !(ZERO_EN && wa0 == '0);
  assign keep1  = we1 && !(ZERO_EN && wa1 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      CLEAR: begin
        cntNext = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          stateNext = READY;
          cntNext   = '0;
        end
      end
      READY: begin
        if (clr_req) begin
          stateNext = CLEAR;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = CLEAR;
        cntNext   = '0;
      end
    endcase
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wrOpen) begin
        if (keep0) mem[wa0] <= wd0;
        if (keep1) mem[wa1] <= wd1;
      end
    end
  end

  always_comb begin
    rd0 = '0;
    if (ready && !(ZERO_EN && ra0 == '0)) begin
      if (!clr_req && we1 && wa1 == ra0)      rd0 = wd1;
      else if (!clr_req && we0 && wa0 == ra0) rd0 = wd0;
      else                                    rd0 = mem[ra0];
    end
  end

  always_comb begin
    rd1 = '0;
    if (ready && !(ZERO_EN && ra1 == '0)) begin
      if (!clr_req && we1 && wa1 == ra1)      rd1 = wd1;
      else if (!clr_req && we0 && wa0 == ra1) rd1 = wd0;
      else                                    rd1 = mem[ra1];
    end
  end

endmodule

// File: tb/tb_regfile_mp_clr.sv
// Scoreboard bench for regfile_mp_clr: two instances (ZERO_REG=1 and 0) share
// stimulus; a reference model predicts every cycle's outputs into a queue.
module tb_regfile_mp_clr;

  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst = 1'b1, clr_req = 1'b0;
  logic we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, ra0 = '0, ra1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic readyZ, readyN;
  logic [DW-1:0] rdZ0, rdZ1, rdN0, rdN1;

  regfile_mp_clr #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG(1)) uZ (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(readyZ),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rdZ0), .rd1(rdZ1));

  regfile_mp_clr #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG(0)) uN (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(readyN),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rdN0), .rd1(rdN1));

  typedef struct {
    logic rdy;
    logic [DW-1:0] z0, z1, n0, n1;
  } exp_t;

  exp_t expQ[$];
  int nVec = 0;
  int nBad = 0;

  // Reference model: cycles left in the clear, plus contents of each array.
  int clearLeft = DEPTH;
  logic [DW-1:0] mZ [DEPTH];
  logic [DW-1:0] mN [DEPTH];

  function automatic logic [DW-1:0] predict(input bit zeroReg, input logic [AW-1:0] ra);
    if (clearLeft > 0) return '0;
    if (zeroReg && ra == 0) return '0;
    if (!clr_req && we1 && wa1 == ra) return wd1;
    if (!clr_req && we0 && wa0 == ra) return wd0;
    return zeroReg ? mZ[ra] : mN[ra];
  endfunction

  task automatic applyEdge();
    if (rst) begin
      clearLeft = DEPTH;
    end else if (clearLeft > 0) begin
      clearLeft--;
      if (clearLeft == 0)
        for (int i = 0; i < DEPTH; i++) begin mZ[i] = '0; mN[i] = '0; end
    end else if (clr_req) begin
      clearLeft = DEPTH;
    end else begin
      if (we0) begin
        mN[wa0] = wd0;
        if (wa0 != 0) mZ[wa0] = wd0;
      end
      if (we1) begin
        mN[wa1] = wd1;
        if (wa1 != 0) mZ[wa1] = wd1;
      end
    end
  endtask

  task automatic step(input bit chk = 1'b1);
    exp_t e;
    if (chk) begin
      e.rdy = (clearLeft == 0);
      e.z0 = predict(1'b1, ra0);
      e.z1 = predict(1'b1, ra1);
      e.n0 = predict(1'b0, ra0);
      e.n1 = predict(1'b0, ra1);
      expQ.push_back(e);
    end
    @(posedge clk);
    applyEdge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    nVec++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cmp("readyZ", {31'b0, readyZ}, {31'b0, e.rdy});
        cmp("readyN", {31'b0, readyN}, {31'b0, e.rdy});
        cmp("rdZ0", rdZ0, e.z0);
        cmp("rdZ1", rdZ1, e.z1);
        cmp("rdN0", rdN0, e.n0);
        cmp("rdN1", rdN1, e.n1);
      end
    end
  end

  initial begin
    int readyAt;
    for (int i = 0; i < DEPTH; i++) begin mZ[i] = '0; mN[i] = '0; end

    // Reset for two cycles; first cycle has no defined state yet.
    rst = 1'b1;
    step(1'b0);
    step();
    idle();
    ra0 = 5;
    readyAt = -1;
    for (int i = 0; i < DEPTH + 8; i++) begin
      ra1 = AW'(i);
      if (readyAt < 0 && readyZ) readyAt = i;
      step();
    end
    cmp("readyLatency", 32'(readyAt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      ra0 = AW'(i); ra1 = AW'(DEPTH - 1 - i);
      step();
    end

    // Single write with bypass, then read from the array.
    we0 = 1'b1; wa0 = 3; wd0 = 32'hDEADBEEF; ra0 = 3; ra1 = 4;
    step();
    idle();
    step();

    // Same-address collision, then distinct addresses.
    we0 = 1'b1; wa0 = 7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h22222222; ra0 = 7; ra1 = 7;
    step();
    idle();
    step();
    we0 = 1'b1; wa0 = 8; wd0 = 32'h33333333;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h44444444; ra0 = 8; ra1 = 7;
    step();
    idle();
    step();

    // Register 0 write: dropped in uZ, stored in uN.
    we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFFFFFF; ra0 = 0; ra1 = 0;
    step();
    idle();
    step();

    // Fill 1..4, then clear request with a simultaneous write.
    for (int i = 1; i <= 4; i++) begin
      we0 = 1'b1; wa0 = AW'(i); wd0 = 32'h100 + 32'(i); ra0 = AW'(i); ra1 = AW'(i);
      step();
    end
    we0 = 1'b1; wa0 = 9; wd0 = 32'h5; clr_req = 1'b1; ra0 = 9; ra1 = 1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      we0 = 1'b1; wa0 = AW'($urandom); wd0 = $urandom;
      we1 = 1'b1; wa1 = AW'($urandom); wd1 = $urandom;
      clr_req = ($urandom_range(0, 3) == 0);
      ra0 = AW'($urandom); ra1 = 9;
      step();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      ra0 = AW'(i); ra1 = 9;
      step();
    end

    // Reset in the middle of a clear restarts it.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    readyAt = -1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (readyAt < 0 && readyZ) readyAt = i;
      ra0 = AW'($urandom); ra1 = AW'($urandom);
      step();
    end
    cmp("restartLatency", 32'(readyAt), 32'(DEPTH));

    // Random traffic with occasional clear requests and resets.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      we0 = $urandom_range(0, 1) == 1; wa0 = AW'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = $urandom_range(0, 1) == 1; wa1 = AW'($urandom_range(0, 7)); wd1 = $urandom;
      ra0 = AW'($urandom_range(0, 7)); ra1 = AW'($urandom_range(0, 7));
      step();
    end
    idle();

    repeat (4) @(negedge clk);
    cmp("queueDrained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
